mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Only one transaction is outstanding at a time.
- Arbitration is fixed-priority: the LS (load/store) side wins, with a starvation guard so fetch is not locked out.
- Sits between the IFU/MEMU request interfaces and the memory backend (DPI mem_read/mem_write wrapper or bus bridge).

Parameters:
ADDR_W, 64, address width of all ports
STARVE_LIMIT, 4, consecutive LS grants with if_req pending before fetch is forced a grant (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch read request, held until if_ready
if_addr  input  ADDR_W  fetch address, 4-byte aligned
if_cancel  input  1  fetch flush (branch/exception); discards the in-flight fetch response
if_ready  output  1  fetch request accepted (1-cycle pulse)
if_rvalid  output  1  fetch data valid (1-cycle pulse)
if_rdata  output  32  instruction word
ls_req  input  1  LS request, held until ls_ready
ls_wr  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  LS byte address
ls_wdata  input  64  store data, already lane-aligned
ls_wmask  input  8  store byte enables
ls_ready  output  1  LS request accepted (1-cycle pulse)
ls_rvalid  output  1  load data valid / store complete (1-cycle pulse)
ls_rdata  output  64  load doubleword (raw, unshifted)
mem_req  output  1  backend request valid
mem_wr  output  1  backend write
mem_addr  output  ADDR_W  backend address
mem_wdata  output  64  backend write data
mem_wmask  output  8  backend byte enables
mem_ready  input  1  backend accepted request
mem_rvalid  input  1  backend response (read data or write ack)
mem_rdata  input  64  backend read data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=IF, starve_cnt=0, cancel_pend=0.
  - All outputs 0, including the mem_* registers.
  - Reset mid-transaction drops the transaction; the backend must be reset together with this block.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Grant rule: ls_req && !(if_req && starve_cnt==STARVE_LIMIT) -> grant LS; else if if_req -> grant IF; else stay.
  - On grant: pulse that side's ready combinationally in this cycle.
  - Register mem_addr/mem_wr/mem_wdata/mem_wmask and owner. For IF: mem_wr=0, wmask=0, wdata=0.
  - Next state REQ.
- REQ:
  - mem_req=1; all mem_* fields held stable.
  - mem_ready=1 -> RESP (mem_req drops the next cycle).
- RESP:
  - mem_rvalid=1 -> route the response to the owner combinationally in the same cycle, then go to IDLE.
  - IF owner: if_rdata = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]; if_rvalid = !cancel_pend && !if_cancel.
  - LS owner: ls_rdata = mem_rdata; ls_rvalid=1 for both loads and stores.
- mem_rvalid outside RESP is ignored. The backend guarantees mem_rvalid no earlier than the cycle after mem_ready.
- Minimum transaction time is 3 cycles (IDLE grant, REQ with mem_ready=1, RESP with mem_rvalid=1). Back-to-back grant is possible on the cycle after RESP.
- Cancel:
  - if_cancel while owner=IF in REQ or RESP sets cancel_pend.
  - The transaction still completes on the backend; the response is swallowed (if_rvalid stays 0).
  - cancel_pend clears on entry to IDLE.
  - if_cancel in IDLE or with owner=LS has no effect.
  - A new if_req in the same cycle as if_cancel is not granted until IDLE.
- Starvation counter:
  - Increment (saturating at STARVE_LIMIT) on each LS grant while if_req=1.
  - Clear on an IF grant, or in IDLE when if_req=0.
- The ready outputs are only ever 1 in IDLE; if_ready and ls_ready are never 1 in the same cycle.
- Requester fields are sampled only in the grant cycle; later changes have no effect.

Test Plan:
- Single fetch: if_req=1, if_addr=0x80000004; backend answers mem_ready next cycle, mem_rvalid 2 cycles later with mem_rdata=0x11112222_33334444 -> if_ready in cycle 0, mem_req for 1 cycle with mem_addr=0x80000004 and mem_wr=0, if_rdata=0x11112222 with if_rvalid pulse, back to IDLE.
- Simultaneous: if_req=1 and ls_req=1 (load, 0x80001000) in the same cycle -> ls_ready first and the LS transaction completes; if_ready is granted in the next IDLE cycle.
- Store: ls_req=1, ls_wr=1, ls_addr=0x80002008, wdata=0xDEADBEEF_00000000, wmask=0xF0 -> mem_req with mem_wr=1, identical fields held through 3 cycles of mem_ready=0, then ls_rvalid pulses on the ack.
- Starvation, STARVE_LIMIT=4: ls_req held continuously with if_req=1 -> 4 LS grants, then the 5th grant goes to IF; starve_cnt returns to 0.
- Cancel: IF transaction in RESP, if_cancel=1 one cycle before mem_rvalid -> if_rvalid stays 0 and the FSM returns to IDLE; a subsequent fetch to 0x80000100 completes normally.
- Async reset asserted during REQ -> mem_req=0 immediately (no clock edge needed); after release, state=IDLE and no stale rvalid appears.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Load/store has priority; a starvation counter forces a fetch grant after STARVE_LIMIT LS wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [63:0]       ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [63:0]       ls_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       cancel_pend;
  logic       grant_ls, grant_if, resp_done;

  assign grant_ls  = ls_req && !(if_req && starve_cnt == LIMIT);
  assign grant_if  = !grant_ls && if_req;
  assign resp_done = (state == RESP) && mem_rvalid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ls || grant_if) state_next = REQ;
      REQ:     if (mem_ready)            state_next = RESP;
      RESP:    if (mem_rvalid)           state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Readies are also held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    mem_req   = (state == REQ);
    if (state == IDLE && reset) begin
      ls_ready = grant_ls;
      if_ready = grant_if;
    end
    if (resp_done) begin
      if (owner == OWN_IF) begin
        if_rdata  = mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        if_rvalid = !cancel_pend && !if_cancel;
      end else begin
        ls_rdata  = mem_rdata;
        ls_rvalid = 1'b1;
      end
    end
  end

  // NOTE: the request registers are reset too, because they drive module outputs directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner       <= OWN_IF;
      starve_cnt  <= '0;
      cancel_pend <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wmask   <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_ls) begin
          owner     <= OWN_LS;
          mem_wr    <= ls_wr;
          mem_addr  <= ls_addr;
          mem_wdata <= ls_wdata;
          mem_wmask <= ls_wmask;
        end else if (grant_if) begin
          owner     <= OWN_IF;
          mem_wr    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wmask <= '0;
        end
        if (grant_if || !if_req)                 starve_cnt <= '0;
        else if (grant_ls && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end
      // Leaving RESP re-arms the flag; a cancel during an IF transaction swallows its response.
      if (resp_done)
        cancel_pend <= 1'b0;
      else if (state != IDLE && owner == OWN_IF && if_cancel)
        cancel_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: backend handshakes are driven by hand cycle by cycle.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, ls_req, ls_wr;
  logic [63:0] if_addr, ls_addr, ls_wdata;
  logic [7:0]  ls_wmask;
  logic        if_ready, if_rvalid, ls_ready, ls_rvalid;
  logic [31:0] if_rdata;
  logic [63:0] ls_rdata;
  logic        mem_req, mem_wr, mem_ready, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0;
    if_req = 0; if_addr = '0; if_cancel = 0;
    ls_req = 0; ls_wr = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;

    // Reset: outputs low even with a pending fetch request
    if_req = 1'b1;
    #3;
    check("rst_if_ready", 64'(if_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    if_req = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Single fetch to 0x80000004, rvalid one cycle after RESP entry
    tick();
    if_req = 1; if_addr = 64'h8000_0004;
    #1;
    check("f1_if_ready", 64'(if_ready), 64'd1);
    check("f1_ls_ready", 64'(ls_ready), 64'd0);
    check("f1_mem_req_idle", 64'(mem_req), 64'd0);
    tick();
    if_req = 0; mem_ready = 1;
    #1;
    check("f1_mem_req", 64'(mem_req), 64'd1);
    check("f1_mem_addr", mem_addr, 64'h8000_0004);
    check("f1_mem_wr", 64'(mem_wr), 64'd0);
    check("f1_mem_wmask", 64'(mem_wmask), 64'd0);
    check("f1_if_ready_req", 64'(if_ready), 64'd0);
    tick();
    mem_ready = 0;
    #1;
    check("f1_mem_req_resp", 64'(mem_req), 64'd0);
    check("f1_if_rvalid_wait", 64'(if_rvalid), 64'd0);
    tick();
    mem_rvalid = 1; mem_rdata = 64'h1111_2222_3333_4444;
    #1;
    check("f1_if_rvalid", 64'(if_rvalid), 64'd1);
    check("f1_if_rdata", 64'(if_rdata), 64'h1111_2222);
    check("f1_ls_rvalid", 64'(ls_rvalid), 64'd0);

    // Simultaneous requests: LS load first, then IF
    tick();
    mem_rvalid = 0;
    if_req = 1; if_addr = 64'h8000_0008;
    ls_req = 1; ls_wr = 0; ls_addr = 64'h8000_1000;
    #1;
    check("sim_ls_ready", 64'(ls_ready), 64'd1);
    check("sim_if_ready", 64'(if_ready), 64'd0);
    tick();
    ls_req = 0; mem_ready = 1;
    #1;
    check("sim_ls_addr", mem_addr, 64'h8000_1000);
    check("sim_ls_wr", 64'(mem_wr), 64'd0);
    check("sim_if_ready_req", 64'(if_ready), 64'd0);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    check("sim_ls_rvalid", 64'(ls_rvalid), 64'd1);
    check("sim_ls_rdata", ls_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    check("sim_if_rvalid_ls", 64'(if_rvalid), 64'd0);
    tick();
    mem_rvalid = 0;
    #1;
    check("sim_if_ready2", 64'(if_ready), 64'd1);
    tick();
    if_req = 0; mem_ready = 1;
    #1;
    check("sim_if_addr", mem_addr, 64'h8000_0008);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h5555_6666_7777_8888;
    #1;
    check("sim_if_rdata_lo", 64'(if_rdata), 64'h7777_8888);
    check("sim_if_rvalid", 64'(if_rvalid), 64'd1);

    // Store with three stall cycles; requester fields change after the grant
    tick();
    mem_rvalid = 0;
    ls_req = 1; ls_wr = 1; ls_addr = 64'h8000_2008;
    ls_wdata = 64'hDEAD_BEEF_0000_0000; ls_wmask = 8'hF0;
    #1;
    check("st_ls_ready", 64'(ls_ready), 64'd1);
    tick();
    ls_req = 0; ls_wr = 0; ls_addr = 64'h1234; ls_wdata = '1; ls_wmask = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_hold_req", 64'(mem_req), 64'd1);
      check("st_hold_wr", 64'(mem_wr), 64'd1);
      check("st_hold_addr", mem_addr, 64'h8000_2008);
      check("st_hold_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
      check("st_hold_wmask", 64'(mem_wmask), 64'hF0);
      tick();
    end
    mem_ready = 1;
    #1;
    check("st_req_accept", 64'(mem_req), 64'd1);
    tick();
    mem_ready = 0;
    #1;
    check("st_no_ack_yet", 64'(ls_rvalid), 64'd0);
    tick();
    mem_rvalid = 1; mem_rdata = '0;
    #1;
    check("st_ack", 64'(ls_rvalid), 64'd1);

    // Starvation: both requesters held; expect LS x4, IF, then LS again
    tick();
    mem_rvalid = 0;
    if_req = 1; if_addr = 64'h8000_0010;
    ls_req = 1; ls_wr = 0; ls_addr = 64'h8000_3000;
    for (int g = 0; g < 6; g++) begin
      #1;
      check("sv_ls_ready", 64'(ls_ready), (g == 4) ? 64'd0 : 64'd1);
      check("sv_if_ready", 64'(if_ready), (g == 4) ? 64'd1 : 64'd0);
      tick();
      if (g == 5) begin
        if_req = 0; ls_req = 0;
      end
      mem_ready = 1;
      #1;
      check("sv_mem_addr", mem_addr, (g == 4) ? 64'h8000_0010 : 64'h8000_3000);
      tick();
      mem_ready = 0; mem_rvalid = 1;
      tick();
      mem_rvalid = 0;
    end

    // Cancel one cycle before the response, then a clean fetch
    if_req = 1; if_addr = 64'h8000_0040;
    #1;
    check("cx_if_ready", 64'(if_ready), 64'd1);
    tick();
    if_req = 0; mem_ready = 1;
    tick();
    mem_ready = 0; if_cancel = 1;
    #1;
    check("cx_rvalid_cancel", 64'(if_rvalid), 64'd0);
    tick();
    if_cancel = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("cx_swallowed", 64'(if_rvalid), 64'd0);
    tick();
    mem_rvalid = 0; if_req = 1; if_addr = 64'h8000_0100;
    #1;
    check("cx_next_ready", 64'(if_ready), 64'd1);
    tick();
    if_req = 0; mem_ready = 1;
    #1;
    check("cx_next_addr", mem_addr, 64'h8000_0100);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    check("cx_next_rvalid", 64'(if_rvalid), 64'd1);
    check("cx_next_rdata", 64'(if_rdata), 64'h89AB_CDEF);

    // Async reset during REQ
    tick();
    mem_rvalid = 0; if_req = 1; if_addr = 64'h8000_0200;
    tick();
    if_req = 0;
    #1;
    check("ar_req_before", 64'(mem_req), 64'd1);
    reset = 0;
    #1;
    check("ar_req_dropped", 64'(mem_req), 64'd0);
    check("ar_addr_cleared", mem_addr, 64'd0);
    tick();
    reset = 1; mem_rvalid = 1;
    #1;
    check("ar_no_stale_if", 64'(if_rvalid), 64'd0);
    check("ar_no_stale_ls", 64'(ls_rvalid), 64'd0);
    tick();
    mem_rvalid = 0;
    #1;
    check("ar_idle_no_req", 64'(mem_req), 64'd0);
    check("ar_idle_no_ready", 64'(if_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
